// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the unidade_controle processor control unit.
// Holds the FSM state encoding, the opcode constants and the positions
// of the opcode / X / Y fields, measured down from the instruction MSB
// so they stay valid for any instruction width W.
package unidade_controle_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Each field is 3 bits; its MSB sits this many bits below the word MSB
  // plus one, i.e. opcode = ir[W-1 -: 3], X = ir[W-4 -: 3], Y = ir[W-7 -: 3].
  localparam int FIELD_W   = 3;
  localparam int OP_MSB_OFS = 1;
  localparam int X_MSB_OFS  = 4;
  localparam int Y_MSB_OFS  = 7;

  // add and sub are the only three-step instructions.
  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/unidade_controle_dec3to8.sv
// 3-to-8 one-hot decoder with enable.
// Ports:
//   w  - 3-bit index
//   en - when 0 the output is all zeros
//   y  - one-hot result, y[w] = 1 when enabled
module dec3to8 (
  input  logic [2:0] w,
  input  logic       en,
  output logic [7:0] y
);

  assign y = en ? (8'd1 << w) : 8'd0;

endmodule

// File: rtl/unidade_controle.sv
// Control unit of a simple multi-cycle processor (mv, mvi, add, sub).
// A four-state FSM (T0..T3) fetches an instruction into an internal IR
// and sequences the datapath strobes for it.
// Ports:
//   Clock, Resetn   - rising-edge clock, asynchronous active-low reset
//   Run             - request to fetch a new instruction (sampled in T0 only)
//   Din[W-1:0]      - instruction word: opcode, X, Y in the top 9 bits
//   controlReg[7:0] - one-hot register bus-drive select (bit n = Rn)
//   Gout, DINout    - bus drive from G and from Din
//   Rin[7:0]        - register load enables (bit n = Rn)
//   IRin, Ain, Gin  - IR / A / G load enables
//   AddSub          - ALU operation, 0 add / 1 sub
//   Done            - one-cycle pulse on the last step of each instruction
// All outputs are combinational from state, IR and (in T0) Run; W >= 10.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Run,
  input  logic [W-1:0] Din,
  output logic [7:0]   controlReg,
  output logic         Gout,
  output logic         DINout,
  output logic [7:0]   Rin,
  output logic         IRin,
  output logic         Ain,
  output logic         Gin,
  output logic         AddSub,
  output logic         Done
);

  state_t       state;
  logic [W-1:0] ir;

  logic [2:0] op;
  logic [2:0] fx;
  logic [2:0] fy;

  assign op = ir[W-OP_MSB_OFS -: FIELD_W];
  assign fx = ir[W-X_MSB_OFS  -: FIELD_W];
  assign fy = ir[W-Y_MSB_OFS  -: FIELD_W];

  // Low IR bits carry no control information.
  logic unused_ir_low;
  assign unused_ir_low = ^ir[W-10:0];

  // State and IR; the fetch edge loads IR and leaves T0 together.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      case (state)
        T0: begin
          if (Run) begin
            ir    <= Din;
            state <= T1;
          end
        end
        T1:      state <= is_alu(op) ? T2 : T0;
        T2:      state <= T3;
        T3:      state <= T0;
        default: state <= T0;
      endcase
    end
  end

  // Decoder controls: the bus source is X in T1 of add/sub and Y otherwise;
  // the load destination is always X.
  logic [2:0] src_sel;
  logic       src_en;
  logic       dst_en;

  always_comb begin
    src_sel = fy;
    src_en  = 1'b0;
    dst_en  = 1'b0;
    Gout    = 1'b0;
    DINout  = 1'b0;
    IRin    = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;
    case (state)
      T0: begin
        // Gated by Resetn so IRin stays low while reset is held.
        IRin = Run & Resetn;
      end
      T1: begin
        if (op == OP_MV) begin
          src_en = 1'b1;
          dst_en = 1'b1;
          Done   = 1'b1;
        end else if (op == OP_MVI) begin
          DINout = 1'b1;
          dst_en = 1'b1;
          Done   = 1'b1;
        end else if (is_alu(op)) begin
          src_sel = fx;
          src_en  = 1'b1;
          Ain     = 1'b1;
        end else begin
          Done = 1'b1;
        end
      end
      T2: begin
        src_en = 1'b1;
        Gin    = 1'b1;
        AddSub = op[0];
      end
      T3: begin
        Gout   = 1'b1;
        dst_en = 1'b1;
        Done   = 1'b1;
      end
      default: ;
    endcase
  end

  dec3to8 u_dec_src (
    .w  (src_sel),
    .en (src_en),
    .y  (controlReg)
  );

  dec3to8 u_dec_dst (
    .w  (fx),
    .en (dst_en),
    .y  (Rin)
  );

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic [15:0] Din;
  logic [7:0]  controlReg;
  logic        Gout;
  logic        DINout;
  logic [7:0]  Rin;
  logic        IRin;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        Done;

  unidade_controle #(.W(16)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Run        (Run),
    .Din        (Din),
    .controlReg (controlReg),
    .Gout       (Gout),
    .DINout     (DINout),
    .Rin        (Rin),
    .IRin       (IRin),
    .Ain        (Ain),
    .Gin        (Gin),
    .AddSub     (AddSub),
    .Done       (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Packed output vector: {controlReg, Gout, DINout, Rin, IRin, Ain, Gin, AddSub, Done}
  typedef struct {
    logic [22:0] exp;
    int          id;
  } item_t;

  item_t sb[$];
  int total = 0;
  int bad   = 0;
  int step_id = 0;

  localparam logic [15:0] JUNK = 16'hFFFF;

  function automatic logic [22:0] ex(input logic [7:0] c, input logic g, input logic d,
                                     input logic [7:0] r, input logic ir, input logic a,
                                     input logic gi, input logic asb, input logic dn);
    return {c, g, d, r, ir, a, gi, asb, dn};
  endfunction

  function automatic logic [15:0] ins(input logic [2:0] op, input logic [2:0] x,
                                      input logic [2:0] y);
    return {op, x, y, 7'b0};
  endfunction

  localparam logic [22:0] ZERO  = 23'd0;
  localparam logic [22:0] FETCH = 23'b000000000_00000000_10000;

  // Drive one cycle of stimulus just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic step(input logic rn, input logic run, input logic [15:0] din,
                      input logic [22:0] e);
    item_t it;
    @(posedge Clock);
    #1;
    Resetn = rn;
    Run    = run;
    Din    = din;
    step_id++;
    it.exp = e;
    it.id  = step_id;
    sb.push_back(it);
  endtask

  // Monitor: on each falling edge check the bus/load exclusivity and compare
  // the outputs against the oldest queued expectation.
  always @(negedge Clock) begin
    logic [22:0] act;
    item_t it;
    act = {controlReg, Gout, DINout, Rin, IRin, Ain, Gin, AddSub, Done};
    total++;
    if ($countones({controlReg, Gout, DINout}) > 1 || $countones(Rin) > 1) begin
      bad++;
      $display("FAIL onehot t=%0t bus=%b rin=%b required at most one bit each",
               $time, {controlReg, Gout, DINout}, Rin);
    end
    if (sb.size() > 0) begin
      it = sb.pop_front();
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL step%0d outputs got=%b want=%b (ctrl,G,DIN,Rin,IR,A,Gin,AS,Done)",
                 it.id, act, it.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    Resetn = 1'b0;
    Run    = 1'b0;
    Din    = '0;

    // Reset held with Run=1: everything, including IRin, stays 0.
    step(1'b0, 1'b1, ins(3'b001, 3'd5, 3'd0), ZERO);
    step(1'b0, 1'b1, ins(3'b001, 3'd5, 3'd0), ZERO);
    step(1'b1, 1'b0, JUNK, ZERO);
    step(1'b1, 1'b0, JUNK, ZERO);

    // mvi R5
    step(1'b1, 1'b1, ins(3'b001, 3'd5, 3'd0), FETCH);
    step(1'b1, 1'b0, JUNK, ex(8'h00, 0, 1, 8'b0010_0000, 0, 0, 0, 0, 1));
    step(1'b1, 1'b0, JUNK, ZERO);

    // mv R2,R6 (Run=1 in T1 must be ignored)
    step(1'b1, 1'b1, ins(3'b000, 3'd2, 3'd6), FETCH);
    step(1'b1, 1'b1, JUNK, ex(8'b0100_0000, 0, 0, 8'b0000_0100, 0, 0, 0, 0, 1));
    step(1'b1, 1'b0, JUNK, ZERO);

    // sub R1,R7
    step(1'b1, 1'b1, ins(3'b011, 3'd1, 3'd7), FETCH);
    step(1'b1, 1'b1, JUNK, ex(8'b0000_0010, 0, 0, 8'h00, 0, 1, 0, 0, 0));
    step(1'b1, 1'b1, JUNK, ex(8'b1000_0000, 0, 0, 8'h00, 0, 0, 1, 1, 0));
    step(1'b1, 1'b1, JUNK, ex(8'h00, 1, 0, 8'b0000_0010, 0, 0, 0, 0, 1));
    step(1'b1, 1'b0, JUNK, ZERO);

    // add R3,R3 (X = Y)
    step(1'b1, 1'b1, ins(3'b010, 3'd3, 3'd3), FETCH);
    step(1'b1, 1'b0, JUNK, ex(8'b0000_1000, 0, 0, 8'h00, 0, 1, 0, 0, 0));
    step(1'b1, 1'b0, JUNK, ex(8'b0000_1000, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    step(1'b1, 1'b0, JUNK, ex(8'h00, 1, 0, 8'b0000_1000, 0, 0, 0, 0, 1));
    step(1'b1, 1'b0, JUNK, ZERO);

    // opcode 101: Done only
    step(1'b1, 1'b1, ins(3'b101, 3'd4, 3'd2), FETCH);
    step(1'b1, 1'b0, JUNK, ex(8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1));
    step(1'b1, 1'b0, JUNK, ZERO);

    // Back-to-back with Run held: mv R0,R1 ; add R4,R5 ; opcode 111
    step(1'b1, 1'b1, ins(3'b000, 3'd0, 3'd1), FETCH);
    step(1'b1, 1'b1, ins(3'b010, 3'd4, 3'd5), ex(8'b0000_0010, 0, 0, 8'b0000_0001, 0, 0, 0, 0, 1));
    step(1'b1, 1'b1, ins(3'b010, 3'd4, 3'd5), FETCH);
    step(1'b1, 1'b1, ins(3'b111, 3'd0, 3'd0), ex(8'b0001_0000, 0, 0, 8'h00, 0, 1, 0, 0, 0));
    step(1'b1, 1'b1, ins(3'b111, 3'd0, 3'd0), ex(8'b0010_0000, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    step(1'b1, 1'b1, ins(3'b111, 3'd0, 3'd0), ex(8'h00, 1, 0, 8'b0001_0000, 0, 0, 0, 0, 1));
    step(1'b1, 1'b1, ins(3'b111, 3'd0, 3'd0), FETCH);
    step(1'b1, 1'b1, JUNK, ex(8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1));
    step(1'b1, 1'b0, JUNK, ZERO);

    // Reset in the middle of add R2,R3: asserted asynchronously during T2.
    step(1'b1, 1'b1, ins(3'b010, 3'd2, 3'd3), FETCH);
    step(1'b1, 1'b1, JUNK, ex(8'b0000_0100, 0, 0, 8'h00, 0, 1, 0, 0, 0));
    step(1'b1, 1'b1, JUNK, ex(8'b0000_1000, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    @(negedge Clock);
    #2;
    Resetn = 1'b0;
    step(1'b0, 1'b1, JUNK, ZERO);
    step(1'b0, 1'b1, JUNK, ZERO);
    // Release: no Gin/Rin/Done may follow.
    step(1'b1, 1'b0, JUNK, ZERO);
    step(1'b1, 1'b0, JUNK, ZERO);
    // First Run=1 edge after release fetches: mv R7,R0
    step(1'b1, 1'b1, ins(3'b000, 3'd7, 3'd0), FETCH);
    step(1'b1, 1'b0, JUNK, ex(8'b0000_0001, 0, 0, 8'b1000_0000, 0, 0, 0, 0, 1));
    step(1'b1, 1'b0, JUNK, ZERO);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge Clock);
      wait_cnt++;
    end
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
